// File: rtl/devtbl_scan_pkg.sv
// Shared definitions for the Device Table scanner: pi1 op encodings, entry layout
// constants and scanner state encoding.
package devtbl_scan_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  // Each entry is two words: DevID at the even word, {mapsz, 0.., useintr} at the odd word.
  localparam int ENTRY_WORDS = 2;
  localparam int ID_WORD     = 0;
  localparam int SZ_WORD     = 1;
  localparam int USEINTR_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    RDID,
    WID,
    RDSZ,
    WSZ,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/devtbl_entry_dec.sv
// Splits a Device Table size word into its byte map size and interrupt-use flag.
module devtbl_entry_dec
  import devtbl_scan_pkg::*;
#(
  parameter int ARCHBITSZ = 16
) (
  input  logic [ARCHBITSZ-1:0] word,
  output logic [ARCHBITSZ-1:0] sz,
  output logic                 useintr
);

  localparam int                   LSB    = clog2(ARCHBITSZ / 8);
  localparam logic [ARCHBITSZ-1:0] LOMASK = ARCHBITSZ'((1 << LSB) - 1);

  assign sz      = word & ~LOMASK;
  assign useintr = word[USEINTR_BIT];

endmodule

// File: rtl/devtbl_scan.sv
// Walks the Device Table over pi1, one read at a time, and reports the first entry
// whose DevID matches the request together with its byte base and interrupt index.
module devtbl_scan
  import devtbl_scan_pkg::*;
#(
  parameter  int ARCHBITSZ  = 16,
  parameter  int DEVTBLADDR = 512,
  parameter  int MAXDEV     = 16,
  localparam int ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int IDXW       = clog2(MAXDEV + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ARCHBITSZ-1:0]   match_id_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   found_o,
  output logic [ARCHBITSZ-1:0]   base_o,
  output logic [ARCHBITSZ-1:0]   mapsz_o,
  output logic                   useintr_o,
  output logic [IDXW-1:0]        intridx_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  input  logic                   pi1_rdy_i
);

  localparam logic [ADDRBITSZ-1:0] TBL_WADDR = ADDRBITSZ'(DEVTBLADDR / (ARCHBITSZ / 8));

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [ADDRBITSZ-1:0]   addr_q, addr_d;
  logic [ARCHBITSZ-1:0]   match_q, id_q, acc_q;
  logic [IDXW-1:0]        n_q, ic_q;
  logic [ARCHBITSZ-1:0]   sz;
  logic                   ui;
  logic                   hit, last_entry, accept;

  function automatic logic [ADDRBITSZ-1:0] entry_addr(input logic [IDXW-1:0] idx,
                                                      input int ofs);
    return TBL_WADDR + ADDRBITSZ'(idx) * ADDRBITSZ'(ENTRY_WORDS) + ADDRBITSZ'(ofs);
  endfunction

  devtbl_entry_dec #(
    .ARCHBITSZ(ARCHBITSZ)
  ) u_dec (
    .word   (pi1_data_i),
    .sz     (sz),
    .useintr(ui)
  );

  assign accept     = (state_q == IDLE) && start_i;
  assign hit        = (state_q == WSZ) && (id_q == match_q);
  assign last_entry = (n_q + 1'b1) == IDXW'(MAXDEV);

  // Next-state logic; op/addr are computed one cycle ahead so the bus sees registers.
  always_comb begin
    state_d = state_q;
    op_d    = PINOOP;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RDID;
          op_d    = PIRDOP;
          addr_d  = entry_addr('0, ID_WORD);
        end
      end
      RDID: begin
        if (pi1_rdy_i) state_d = WID;
        else           op_d    = PIRDOP;
      end
      WID: begin
        if (pi1_data_i == '0) begin
          state_d = DONE;
        end else begin
          state_d = RDSZ;
          op_d    = PIRDOP;
          addr_d  = entry_addr(n_q, SZ_WORD);
        end
      end
      RDSZ: begin
        if (pi1_rdy_i) state_d = WSZ;
        else           op_d    = PIRDOP;
      end
      WSZ: begin
        if (hit || last_entry) begin
          state_d = DONE;
        end else begin
          state_d = RDID;
          op_d    = PIRDOP;
          addr_d  = entry_addr(n_q + 1'b1, ID_WORD);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_q    <= PINOOP;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
    end
  end

  // Result registers: cleared by an accepted start, loaded on a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      found_o   <= 1'b0;
      base_o    <= '0;
      mapsz_o   <= '0;
      useintr_o <= 1'b0;
      intridx_o <= '0;
    end else if (accept) begin
      found_o   <= 1'b0;
      base_o    <= '0;
      mapsz_o   <= '0;
      useintr_o <= 1'b0;
      intridx_o <= '0;
    end else if (hit) begin
      found_o   <= 1'b1;
      base_o    <= acc_q;
      mapsz_o   <= sz;
      useintr_o <= ui;
      intridx_o <= ic_q;
    end
  end

  // Scan accumulators; every one is initialised by the accepted start, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      match_q <= match_id_i;
      n_q     <= '0;
      acc_q   <= '0;
      ic_q    <= '0;
    end
    if (state_q == WID) id_q <= pi1_data_i;
    if ((state_q == WSZ) && !hit) begin
      acc_q <= acc_q + sz;
      ic_q  <= ic_q + IDXW'(ui);
      n_q   <= n_q + 1'b1;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign pi1_op_o   = op_q;
  assign pi1_addr_o = addr_q;
  assign pi1_data_o = '0;
  assign pi1_sel_o  = '1;

endmodule

// File: tb/tb_devtbl_scan.sv
// Directed bench for devtbl_scan: a 32-bit build with MAXDEV=16 and a second
// MAXDEV=2 build, each served by a small Device Table responder model.
module tb_devtbl_scan;
  import devtbl_scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [31:0] match;
  logic        stall_en;

  logic        busy, done, found, ui;
  logic [31:0] base, mapsz, dout, din;
  logic [4:0]  idx;
  logic [1:0]  op;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic        rdy;

  logic        busy2, done2, found2, ui2;
  logic [31:0] base2, mapsz2, dout2, din2;
  logic [1:0]  idx2;
  logic [1:0]  op2;
  logic [29:0] addr2;
  logic [3:0]  sel2;

  logic [31:0] mem [16];

  int nerr = 0;
  int nchk = 0;

  devtbl_scan #(.ARCHBITSZ(32), .DEVTBLADDR(512), .MAXDEV(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .match_id_i(match),
    .busy_o(busy), .done_o(done), .found_o(found), .base_o(base),
    .mapsz_o(mapsz), .useintr_o(ui), .intridx_o(idx),
    .pi1_op_o(op), .pi1_addr_o(addr), .pi1_data_o(dout), .pi1_sel_o(sel),
    .pi1_data_i(din), .pi1_rdy_i(rdy)
  );

  devtbl_scan #(.ARCHBITSZ(32), .DEVTBLADDR(512), .MAXDEV(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .match_id_i(match),
    .busy_o(busy2), .done_o(done2), .found_o(found2), .base_o(base2),
    .mapsz_o(mapsz2), .useintr_o(ui2), .intridx_o(idx2),
    .pi1_op_o(op2), .pi1_addr_o(addr2), .pi1_data_o(dout2), .pi1_sel_o(sel2),
    .pi1_data_i(din2), .pi1_rdy_i(1'b1)
  );

  function automatic logic [31:0] rd(input logic [29:0] a);
    logic [29:0] i;
    i = a - 30'h80;
    if (i < 30'd16) return mem[i[3:0]];
    return 32'h0;
  endfunction

  // Responder models: data is returned the cycle after acceptance.
  int          nreads = 0, nreads2 = 0;
  logic [29:0] last_addr = '0, last_addr2 = '0;
  initial din = '0;
  initial din2 = '0;
  always @(posedge clk) begin
    if (op == PIRDOP && rdy) begin
      din       <= rd(addr);
      last_addr <= addr;
      nreads    <= nreads + 1;
    end
  end
  always @(posedge clk) begin
    if (op2 == PIRDOP) begin
      din2       <= rd(addr2);
      last_addr2 <= addr2;
      nreads2    <= nreads2 + 1;
    end
  end

  // Optional back-pressure: each read waits three cycles before being accepted.
  int wcnt = 0;
  assign rdy = !stall_en || (wcnt == 3);
  always @(posedge clk) begin
    if (op == PIRDOP && !rdy) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
  end

  logic        prev_wait = 1'b0;
  logic [29:0] prev_addr = '0;
  int          hold_seen = 0, hold_viol = 0;
  always @(negedge clk) begin
    if (stall_en && prev_wait) begin
      hold_seen <= hold_seen + 1;
      if (op != PIRDOP || addr != prev_addr) hold_viol <= hold_viol + 1;
    end
    prev_wait <= stall_en && (op == PIRDOP) && !rdy;
    prev_addr <= addr;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_a();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'd7; mem[1] = 32'h201;
    mem[2] = 32'd2; mem[3] = 32'hC00;
    mem[4] = 32'd5; mem[5] = 32'h201;
    mem[6] = 32'd1; mem[7] = 32'h4000;
  endtask

  task automatic load_wrap();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'd3; mem[1] = 32'hC000_0001;
    mem[2] = 32'd4; mem[3] = 32'h8000_0000;
    mem[4] = 32'd6; mem[5] = 32'h11;
  endtask

  // Start at edge 0; cycle n is the interval following edge n-1.
  task automatic run_scan(input logic [31:0] m, input int poke_cyc, input logic [31:0] poke_m,
                          output int dcyc, output int d2cyc, output logic [29:0] a1);
    int cyc;
    dcyc  = -1;
    d2cyc = -1;
    a1    = '0;
    @(negedge clk);
    start = 1'b1;
    match = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc == 1) a1 = addr;
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) match = poke_m;
      if (d2cyc < 0 && done2) d2cyc = cyc;
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  int          dc, d2c, r0, r2;
  logic [29:0] a1;
  logic        reached;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    match    = '0;
    stall_en = 1'b0;
    load_a();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op", op, PINOOP);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_base", base, 0);
    chk("rst_idx", idx, 0);
    chk("sel", {sel2, sel}, 8'hFF);
    chk("dout", {dout2, dout}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Match at entry 3 with a zero-wait responder.
    run_scan(32'd1, -1, 32'd0, dc, d2c, a1);
    chk("t1_addr0", a1, 30'h80);
    chk("t1_done_cyc", dc, 17);
    chk("t1_found", found, 1);
    chk("t1_base", base, 32'h1000);
    chk("t1_mapsz", mapsz, 32'h4000);
    chk("t1_ui", ui, 0);
    chk("t1_idx", idx, 2);
    chk("t1_m2_done_cyc", d2c, 9);
    chk("t1_m2_found", found2, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_after", busy, 0);

    // Absent id, table ends at entry 4 (id word 0 at address 0x88).
    r0 = nreads;
    r2 = nreads2;
    run_scan(32'd9, -1, 32'd0, dc, d2c, a1);
    chk("t2_done_cyc", dc, 19);
    chk("t2_found", found, 0);
    chk("t2_last_addr", last_addr, 30'h88);
    chk("t2_reads", nreads - r0, 9);
    chk("t2_m2_done_cyc", d2c, 9);
    chk("t2_m2_found", found2, 0);
    chk("t2_m2_reads", nreads2 - r2, 4);
    chk("t2_m2_res", {base2, mapsz2, ui2, idx2}, 0);
    @(negedge clk);
    chk("t2_m2_busy", busy2, 0);

    // Match at entry 1, first without and then with three stall cycles per read.
    run_scan(32'd2, -1, 32'd0, dc, d2c, a1);
    chk("t3_done_cyc", dc, 9);
    chk("t3_res", {found, base, mapsz, ui, idx}, {1'b1, 32'h200, 32'hC00, 1'b0, 5'd1});
    @(negedge clk);
    stall_en = 1'b1;
    run_scan(32'd2, -1, 32'd0, dc, d2c, a1);
    stall_en = 1'b0;
    chk("t3s_done_cyc", dc, 21);
    chk("t3s_res", {found, base, mapsz, ui, idx}, {1'b1, 32'h200, 32'hC00, 1'b0, 5'd1});
    chk("t3s_hold_seen", hold_seen, 12);
    chk("t3s_hold_viol", hold_viol, 0);

    // Base wraps past 2^32; a start pulse mid-scan must be ignored.
    load_wrap();
    run_scan(32'd6, 5, 32'd3, dc, d2c, a1);
    chk("t4_done_cyc", dc, 13);
    chk("t4_found", found, 1);
    chk("t4_base", base, 32'h4000_0000);
    chk("t4_mapsz", mapsz, 32'h10);
    chk("t4_ui", ui, 1);
    chk("t4_idx", idx, 1);
    chk("t4_m2_found", found2, 0);

    // Reset while the size read of entry 0 is on the bus, then rescan.
    load_a();
    @(negedge clk);
    start = 1'b1;
    match = 32'd1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (op == PIRDOP && addr == 30'h81) begin
        reached = 1'b1;
        break;
      end
    end
    chk("t5_rdsz_reached", reached, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_op", op, PINOOP);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(32'd1, -1, 32'd0, dc, d2c, a1);
    chk("t5_addr0", a1, 30'h80);
    chk("t5_done_cyc", dc, 17);
    chk("t5_res", {found, base, idx}, {1'b1, 32'h1000, 5'd2});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
